// File: rtl/enrg_serial_tx_pkg.sv
// Shared frame definitions for the energy-data serial link.
// Used by the transmitter and by the event-builder CRC checker.
package enrg_serial_tx_pkg;

  localparam int HDR  = 5;
  localparam int PED  = 8;
  localparam int SMP  = 16;
  localparam int CHW  = PED + SMP;
  localparam int CRCW = 6;
  localparam int EVTW = 1 + 2 * CHW;
  localparam int FRW  = HDR + 2 * CHW;

  localparam logic [CRCW-1:0] CRC_POLY = 6'h03;

  typedef enum logic [2:0] {
    Idle,
    Strt,
    Hdr,
    Chan,
    Crc,
    Gap
  } state_t;

  typedef struct packed {
    logic            twoVsThree;
    logic [PED-1:0]  ped2;
    logic [SMP-1:0]  smp2;
    logic [PED-1:0]  ped3;
    logic [SMP-1:0]  smp3;
  } evt_t;

  // One serial step of CRC-6 (x^6+x+1), MSB-first, no reflection.
  function automatic logic [CRCW-1:0] crc6Step(input logic [CRCW-1:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[CRCW-1];
    return {crc[CRCW-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/enrg_serial_tx_if.sv
// Event load / serial status bundle between the digitizer logic and enrg_serial_tx.
interface enrg_serial_tx_if;

  logic [3:0]  Address;
  logic        Load;
  logic        TwoVsThree;
  logic [7:0]  Ped2;
  logic [15:0] Smp2;
  logic [7:0]  Ped3;
  logic [15:0] Smp3;
  logic        Data;
  logic        Busy;
  logic        Full;
  logic [4:0]  NEvt;
  logic        Overflow;

  modport master (
    output Address, Load, TwoVsThree, Ped2, Smp2, Ped3, Smp3,
    input  Data, Busy, Full, NEvt, Overflow
  );

  modport slave (
    input  Address, Load, TwoVsThree, Ped2, Smp2, Ped3, Smp3,
    output Data, Busy, Full, NEvt, Overflow
  );

endinterface

// File: rtl/enrg_serial_tx_crc6_gen.sv
// Serial CRC-6 accumulator, one bit per clock; Clr restarts it at each frame.
module crc6_gen
  import enrg_serial_tx_pkg::*;
(
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Clr,
  input  logic            En,
  input  logic            Din,
  output logic [CRCW-1:0] Crc
);

  always_ff @(posedge Clock) begin
    if (Reset || Clr) begin
      Crc <= '0;
    end else if (En) begin
      Crc <= crc6Step(Crc, Din);
    end
  end

endmodule

// File: rtl/enrg_serial_tx.sv
// Energy-data serial transmitter: event FIFO plus a frame serializer
// emitting start, header, channel words and CRC-6, one bit per clock.
module enrg_serial_tx
  import enrg_serial_tx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int GAP   = 2
)
(
  input  logic Clock,
  input  logic Reset,
  enrg_serial_tx_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  evt_t            fifoMem [DEPTH];
  logic [AW-1:0]   wrPtr;
  logic [AW-1:0]   rdPtr;
  logic [4:0]      count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  evt_t            evtIn;
  evt_t            head;

  state_t          state;
  logic [5:0]      bitCnt;
  logic [FRW-1:0]  shiftReg;
  logic            twoCh;
  logic            crcEn;
  logic            crcDin;
  logic [CRCW-1:0] crcVal;

  assign full  = (count == 5'(DEPTH));
  assign empty = (count == 5'd0);
  assign evtIn = {bus.TwoVsThree, bus.Ped2, bus.Smp2, bus.Ped3, bus.Smp3};
  assign head  = fifoMem[rdPtr];
  assign push  = bus.Load && !full;

  // The last gap cycle doubles as Idle so back-to-back frames keep exactly GAP zeros.
  assign pop = !empty && ((state == Idle) || ((state == Gap) && (bitCnt == 6'd0)));

  assign bus.Full = full;
  assign bus.NEvt = count;

  always_ff @(posedge Clock) begin
    if (push) begin
      fifoMem[wrPtr] <= evtIn;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wrPtr        <= '0;
      rdPtr        <= '0;
      count        <= '0;
      bus.Overflow <= 1'b0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      count        <= count + 5'(push) - 5'(pop);
      bus.Overflow <= bus.Load && full;
    end
  end

  assign crcEn  = (state == Strt) || (state == Hdr) || (state == Chan);
  assign crcDin = (state == Strt) ? 1'b1 : shiftReg[FRW-1];

  crc6_gen u_crc (
    .Clock (Clock),
    .Reset (Reset),
    .Clr   (pop),
    .En    (crcEn),
    .Din   (crcDin),
    .Crc   (crcVal)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= Idle;
      bus.Data <= 1'b0;
      bus.Busy <= 1'b0;
      bitCnt   <= '0;
      shiftReg <= '0;
      twoCh    <= 1'b0;
    end else begin
      // Address is captured together with the popped event fields.
      if (pop) begin
        shiftReg <= {head.twoVsThree, bus.Address, head.ped2, head.smp2, head.ped3, head.smp3};
        twoCh    <= head.twoVsThree;
      end
      case (state)
        Idle: begin
          bus.Data <= 1'b0;
          bus.Busy <= 1'b0;
          if (pop) begin
            state <= Strt;
          end
        end
        Strt: begin
          bus.Data <= 1'b1;
          bus.Busy <= 1'b1;
          bitCnt   <= 6'(HDR - 1);
          state    <= Hdr;
        end
        Hdr: begin
          bus.Data <= shiftReg[FRW-1];
          shiftReg <= {shiftReg[FRW-2:0], 1'b0};
          if (bitCnt == 6'd0) begin
            bitCnt <= twoCh ? 6'(2 * CHW - 1) : 6'(CHW - 1);
            state  <= Chan;
          end else begin
            bitCnt <= bitCnt - 6'd1;
          end
        end
        Chan: begin
          bus.Data <= shiftReg[FRW-1];
          shiftReg <= {shiftReg[FRW-2:0], 1'b0};
          if (bitCnt == 6'd0) begin
            bitCnt <= 6'(CRCW - 1);
            state  <= Crc;
          end else begin
            bitCnt <= bitCnt - 6'd1;
          end
        end
        Crc: begin
          bus.Data <= crcVal[bitCnt[2:0]];
          if (bitCnt == 6'd0) begin
            bitCnt <= 6'(GAP - 1);
            state  <= Gap;
          end else begin
            bitCnt <= bitCnt - 6'd1;
          end
        end
        Gap: begin
          bus.Data <= 1'b0;
          bus.Busy <= 1'b1;
          if (bitCnt == 6'd0) begin
            state <= pop ? Strt : Idle;
          end else begin
            bitCnt <= bitCnt - 6'd1;
          end
        end
        default: begin
          bus.Data <= 1'b0;
          bus.Busy <= 1'b0;
          state    <= Idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enrg_serial_tx.sv
// Bench for enrg_serial_tx: event-level reference model compared every cycle,
// directed frame/timing pins, random traffic and a serial receiver CRC check.
module tb_enrg_serial_tx;

  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  typedef bit bitq_t[$];

  typedef struct packed {
    bit        two;
    bit [7:0]  p2;
    bit [15:0] s2;
    bit [7:0]  p3;
    bit [15:0] s3;
  } tevt_t;

  logic Clock = 1'b0;
  logic Reset;

  enrg_serial_tx_if bus ();

  enrg_serial_tx #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int    nChecks = 0;
  int    nFail   = 0;
  bit    started = 1'b0;

  tevt_t mq[$];
  bit    lineD[$];
  bit    lineL[$];
  bit    expData, expBusy, expOvf;
  int    framesPopped = 0;
  int    framesDone   = 0;

  bit    rxActive = 1'b0;
  bit    rxBits[$];
  bit    lastRx[$];
  int    rxLen    = 0;
  int    rxFrames = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Remainder of the bit polynomial modulo x^6+x+1, by long division.
  function automatic logic [5:0] polyMod(input bitq_t bits, input bit addZeros);
    bit r[$];
    bit [6:0] g;
    logic [5:0] rem;
    g = 7'b1000011;
    r = bits;
    if (addZeros) begin
      for (int k = 0; k < 6; k++) r.push_back(1'b0);
    end
    for (int i = 0; i + 6 < r.size(); i++) begin
      if (r[i]) begin
        for (int j = 0; j < 7; j++) r[i+j] = r[i+j] ^ g[6-j];
      end
    end
    for (int k = 0; k < 6; k++) rem[5-k] = r[r.size()-6+k];
    return rem;
  endfunction

  function automatic bitq_t msgBits(input tevt_t e, input logic [3:0] addr);
    bitq_t m;
    m.push_back(1'b1);
    m.push_back(e.two);
    for (int i = 3; i >= 0; i--) m.push_back(addr[i]);
    for (int i = 7; i >= 0; i--) m.push_back(e.p2[i]);
    for (int i = 15; i >= 0; i--) m.push_back(e.s2[i]);
    if (e.two) begin
      for (int i = 7; i >= 0; i--) m.push_back(e.p3[i]);
      for (int i = 15; i >= 0; i--) m.push_back(e.s3[i]);
    end
    return m;
  endfunction

  task automatic buildFrame(input tevt_t e, input logic [3:0] addr);
    bitq_t m;
    logic [5:0] c;
    m = msgBits(e, addr);
    c = polyMod(m, 1'b1);
    foreach (m[i]) begin
      lineD.push_back(m[i]);
      lineL.push_back(1'b0);
    end
    for (int i = 5; i >= 0; i--) begin
      lineD.push_back(c[i]);
      lineL.push_back(i == 0);
    end
    for (int i = 0; i < GAP; i++) begin
      lineD.push_back(1'b0);
      lineL.push_back(1'b0);
    end
  endtask

  // Reference model: FIFO of events plus a queue of the line bits still to come.
  always @(posedge Clock) begin
    bit isFull;
    tevt_t e;
    started = 1'b1;
    if (Reset) begin
      mq.delete();
      lineD.delete();
      lineL.delete();
      expData = 1'b0;
      expBusy = 1'b0;
      expOvf  = 1'b0;
    end else begin
      isFull = (mq.size() == DEPTH);
      if (lineD.size() > 0) begin
        expData = lineD.pop_front();
        expBusy = 1'b1;
        if (lineL.pop_front()) framesDone++;
      end else begin
        expData = 1'b0;
        expBusy = 1'b0;
      end
      if (lineD.size() == 0 && mq.size() > 0) begin
        e = mq.pop_front();
        buildFrame(e, bus.Address);
        framesPopped++;
      end
      expOvf = bus.Load && isFull;
      if (bus.Load && !isFull) begin
        mq.push_back({bus.TwoVsThree, bus.Ped2, bus.Smp2, bus.Ped3, bus.Smp3});
      end
    end
  end

  always @(negedge Clock) begin
    if (started) begin
      checkOutput("Data", 32'(bus.Data), 32'(expData));
      checkOutput("Busy", 32'(bus.Busy), 32'(expBusy));
      checkOutput("Full", 32'(bus.Full), 32'(mq.size() == DEPTH));
      checkOutput("NEvt", 32'(bus.NEvt), 32'(mq.size()));
      checkOutput("Overflow", 32'(bus.Overflow), 32'(expOvf));
    end
  end

  // Serial receiver: rebuilds frames from Data and checks the CRC residue.
  always @(negedge Clock) begin
    if (Reset) begin
      rxActive = 1'b0;
      rxBits.delete();
    end else if (started) begin
      if (rxActive) begin
        rxBits.push_back(bus.Data);
        if (rxBits.size() == 2) rxLen = rxBits[1] ? 60 : 36;
        if (rxBits.size() == rxLen) begin
          checkOutput("rx_crc_residue", 32'(polyMod(rxBits, 1'b0)), 32'd0);
          rxFrames++;
          lastRx   = rxBits;
          rxActive = 1'b0;
        end
      end else if (bus.Data === 1'b1) begin
        rxActive = 1'b1;
        rxBits.delete();
        rxBits.push_back(1'b1);
        rxLen = 60;
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic applyStimulus(input tevt_t e);
    bus.TwoVsThree = e.two;
    bus.Ped2       = e.p2;
    bus.Smp2       = e.s2;
    bus.Ped3       = e.p3;
    bus.Smp3       = e.s3;
    bus.Load       = 1'b1;
    tick();
    bus.Load       = 1'b0;
  endtask

  task automatic waitIdle();
    int i;
    for (i = 0; i < 2000 && (lineD.size() != 0 || mq.size() != 0); i++) tick();
    checkOutput("idle_reached", 32'(lineD.size() == 0 && mq.size() == 0), 32'd1);
    tick();
  endtask

  function automatic tevt_t randEvt(input bit two);
    tevt_t e;
    e.two = two;
    e.p2  = 8'($urandom);
    e.s2  = 16'($urandom);
    e.p3  = 8'($urandom);
    e.s3  = 16'($urandom);
    return e;
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tevt_t t1, t2;
    logic [35:0] gotFrame, expFrame;
    int n, busyCnt, target;

    Reset = 1'b1;
    bus.Load = 1'b0; bus.Address = 4'h5; bus.TwoVsThree = 1'b0;
    bus.Ped2 = '0; bus.Smp2 = '0; bus.Ped3 = '0; bus.Smp3 = '0;
    repeat (3) tick();
    Reset = 1'b0;
    tick();
    checkOutput("reset_data", 32'(bus.Data), 32'd0);
    checkOutput("reset_busy", 32'(bus.Busy), 32'd0);
    checkOutput("reset_nevt", 32'(bus.NEvt), 32'd0);
    checkOutput("reset_full", 32'(bus.Full), 32'd0);

    t1 = '{two: 1'b0, p2: 8'hF3, s2: 16'h8001, p3: 8'h00, s3: 16'h0000};
    t2 = '{two: 1'b1, p2: 8'hF3, s2: 16'h8001, p3: 8'h7F, s3: 16'h0000};
    checkOutput("model_crc_pin", 32'(polyMod(msgBits(t1, 4'h5), 1'b1)), 32'h38);
    checkOutput("model_len_pin", 32'(msgBits(t2, 4'h5).size() + 6), 32'd60);

    // Single-channel frame: start bit two edges after Load, literal frame content.
    expFrame = {1'b1, 1'b0, 4'h5, 8'hF3, 16'h8001, 6'h38};
    applyStimulus(t1);
    tick();
    checkOutput("t1_data_t1", 32'(bus.Data), 32'd0);
    tick();
    checkOutput("t1_start_t2", 32'(bus.Data), 32'd1);
    gotFrame[35] = bus.Data;
    for (int i = 34; i >= 0; i--) begin
      tick();
      gotFrame[i] = bus.Data;
    end
    checkOutput("t1_frame_hi", 32'(gotFrame[35:18]), 32'(expFrame[35:18]));
    checkOutput("t1_frame_lo", 32'(gotFrame[17:0]), 32'(expFrame[17:0]));
    waitIdle();

    // Two-channel frame: Busy spans 60 frame bits plus GAP.
    applyStimulus(t2);
    for (int i = 0; i < 10 && !bus.Busy; i++) tick();
    checkOutput("t2_busy_rise", 32'(bus.Busy), 32'd1);
    n = 0;
    while (bus.Busy && n < 200) begin
      n++;
      tick();
    end
    checkOutput("t2_busy_len", 32'(n), 32'd62);
    waitIdle();

    // Six consecutive loads into a depth-4 FIFO with one popped early.
    busyCnt = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(randEvt(1'b0));
      busyCnt += int'(bus.Busy);
      if (i == 3) checkOutput("t3_full_4th", 32'(bus.Full), 32'd0);
      if (i == 4) begin
        checkOutput("t3_full_5th", 32'(bus.Full), 32'd1);
        checkOutput("t3_nevt_5th", 32'(bus.NEvt), 32'd4);
        checkOutput("t3_ovf_5th", 32'(bus.Overflow), 32'd0);
      end
      if (i == 5) checkOutput("t3_ovf_6th", 32'(bus.Overflow), 32'd1);
    end
    for (int i = 0; i < 400; i++) begin
      tick();
      busyCnt += int'(bus.Busy);
    end
    checkOutput("t3_busy_total", 32'(busyCnt), 32'd190);
    waitIdle();

    // Load coincident with the pop of the previous event.
    applyStimulus(randEvt(1'b1));
    checkOutput("t4_nevt_first", 32'(bus.NEvt), 32'd1);
    applyStimulus(randEvt(1'b0));
    checkOutput("t4_nevt_pop", 32'(bus.NEvt), 32'd1);
    waitIdle();

    // Reset in the middle of a frame with another event queued.
    applyStimulus(randEvt(1'b1));
    applyStimulus(randEvt(1'b1));
    for (int i = 0; i < 10 && !bus.Busy; i++) tick();
    repeat (20) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checkOutput("t5_data", 32'(bus.Data), 32'd0);
    checkOutput("t5_busy", 32'(bus.Busy), 32'd0);
    checkOutput("t5_nevt", 32'(bus.NEvt), 32'd0);
    tick();
    applyStimulus(randEvt(1'b0));
    waitIdle();

    // Random traffic until 100 further frames have been launched.
    target = framesPopped + 100;
    for (int c = 0; c < 20000 && framesPopped < target; c++) begin
      bus.Address    = 4'($urandom);
      bus.TwoVsThree = 1'($urandom);
      bus.Ped2       = 8'($urandom);
      bus.Smp2       = 16'($urandom);
      bus.Ped3       = 8'($urandom);
      bus.Smp3       = 16'($urandom);
      bus.Load       = ($urandom_range(0, 99) < 6);
      tick();
    end
    bus.Load = 1'b0;
    checkOutput("t6_frames_launched", 32'(framesPopped >= target), 32'd1);
    waitIdle();

    checkOutput("rx_frame_count", 32'(rxFrames), 32'(framesDone));
    if (rxFrames > 0) begin
      bit bad[$];
      bad = lastRx;
      bad[10] = ~bad[10];
      checkOutput("rx_corrupt_detect", 32'(polyMod(bad, 1'b0) != 6'd0), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
